// File: rtl/dmem_pkg.sv
// Shared encodings for the multi-cycle data memory: access sizes, FSM states
// and the alignment rule used by both the controller and the lane unit.
package dmem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'd0;
  localparam logic [1:0] SIZE_BYTE = 2'd1;
  localparam logic [1:0] SIZE_HALF = 2'd2;
  localparam logic [1:0] SIZE_BAD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Size 3 is never legal; byte accesses are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b1;
    case (size)
      SIZE_WORD: bad = (lo != 2'b00);
      SIZE_HALF: bad = lo[0];
      SIZE_BYTE: bad = 1'b0;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Combinational byte-lane unit: merges store data into an old word and
// extracts/extends a load value from the same word.
module dmem_lane_merge
  import dmem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        sign_ext,
  output logic [31:0] merged,
  output logic [31:0] load_val
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Alignment is the caller's concern; this unit only moves lanes.
  always_comb begin
    merged   = old_word;
    load_val = '0;
    byte_v   = old_word[8*lo +: 8];
    half_v   = old_word[16*lo[1] +: 16];
    case (size)
      SIZE_WORD: begin
        merged   = wdata;
        load_val = old_word;
      end
      SIZE_BYTE: begin
        merged[8*lo +: 8] = wdata[7:0];
        load_val          = {{24{sign_ext & byte_v[7]}}, byte_v};
      end
      SIZE_HALF: begin
        merged[16*lo[1] +: 16] = wdata[15:0];
        load_val               = {{16{sign_ext & half_v[15]}}, half_v};
      end
      default: begin
        merged   = old_word;
        load_val = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_mc_ctrl.sv
// Multi-cycle data memory: valid/ready request port, fixed access latency,
// sub-word stores and signed/unsigned sub-word loads with alignment checking.
module dmem_mc_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int LOG_EN  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [1:0]        dbg_state
);

  localparam int IDX_W = ADDR_W - 2;

  // Handshake: a request transfers on any rising edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE, so requests seen
  // while busy are simply not taken and the requester keeps them asserted.

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;

  logic              lat_we;
  logic [1:0]        lat_size;
  logic              lat_signed;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       lat_pc;

  logic [31:0] ram [DEPTH];

  logic              accept;
  logic              commit;
  logic              cur_we;
  logic [1:0]        cur_size;
  logic              cur_signed;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [31:0]       cur_pc;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              bad;
  logic              store_commit;
  logic [31:0]       old_word;
  logic [31:0]       merged_word;
  logic [31:0]       load_word;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_nx   = 4'(LATENCY - 1);
          state_nx = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) state_nx = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_nx   = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign accept    = req_valid && req_ready;
  assign dbg_state = state;

  // The access commits on the edge that enters RESP. With LATENCY==1 that is
  // the accept edge itself, so the live request is used instead of the latch.
  assign commit     = (state_nx == ST_RESP) && (state != ST_RESP);
  assign cur_we     = (state == ST_IDLE) ? req_we     : lat_we;
  assign cur_size   = (state == ST_IDLE) ? req_size   : lat_size;
  assign cur_signed = (state == ST_IDLE) ? req_signed : lat_signed;
  assign cur_addr   = (state == ST_IDLE) ? req_addr   : lat_addr;
  assign cur_wdata  = (state == ST_IDLE) ? req_wdata  : lat_wdata;
  assign cur_pc     = (state == ST_IDLE) ? req_pc     : lat_pc;

  assign idx          = cur_addr[ADDR_W-1:2];
  assign in_range     = (32'(idx) < DEPTH);
  assign bad          = is_misaligned(cur_size, cur_addr[1:0]);
  assign old_word     = in_range ? ram[idx] : '0;
  assign store_commit = commit && cur_we && !bad && in_range;

  dmem_lane_merge u_lane (
    .old_word (old_word),
    .wdata    (cur_wdata),
    .size     (cur_size),
    .lo       (cur_addr[1:0]),
    .sign_ext (cur_signed),
    .merged   (merged_word),
    .load_val (load_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      lat_we     <= 1'b0;
      lat_size   <= SIZE_WORD;
      lat_signed <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_pc     <= '0;
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        lat_we     <= req_we;
        lat_size   <= req_size;
        lat_signed <= req_signed;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
        lat_pc     <= req_pc;
      end
      if (commit) begin
        resp_err   <= bad;
        resp_rdata <= (bad || cur_we) ? 32'd0 : load_word;
      end
      if (store_commit) ram[idx] <= merged_word;
    end
  end

`ifndef SYNTHESIS
  if (LOG_EN != 0) begin : g_log
    always_ff @(posedge clk) begin
      if (!reset && store_commit)
        $display("@%h: *%h <= %h", cur_pc, 32'({cur_addr[ADDR_W-1:2], 2'b00}), merged_word);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_mc_ctrl.sv
// Bench for dmem_mc_ctrl: directed vector table, reset/hold sequences,
// random traffic against a byte-array model, and throughput at LATENCY 1 and 5.
module tb_dmem_mc_ctrl;
  import dmem_pkg::*;

  localparam int ADDR_W   = 12;
  localparam int DEPTH    = 1024;
  localparam int MAIN_LAT = 2;
  localparam int BUDGET   = 50;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic [31:0]       req_pc = '0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [1:0]        dbg_state;

  logic v1 = 1'b0, rdy1, rv1, er1;
  logic [31:0] rd1;
  logic [1:0]  st1;
  logic v5 = 1'b0, rdy5, rv5, er5;
  logic [31:0] rd5;
  logic [1:0]  st5;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0]  mem_b [DEPTH*4];
  logic [32:0] exp_q [$];

  always #5 clk = ~clk;

  dmem_mc_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(MAIN_LAT), .LOG_EN(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
  );

  dmem_mc_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(1), .LOG_EN(0)) dut_l1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1),
    .req_we(1'b0), .req_size(2'd0), .req_signed(1'b0), .req_addr(12'h000),
    .req_wdata(32'd0), .req_pc(32'd0), .resp_valid(rv1),
    .resp_rdata(rd1), .resp_err(er1), .dbg_state(st1)
  );

  dmem_mc_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(5), .LOG_EN(0)) dut_l5 (
    .clk(clk), .reset(reset), .req_valid(v5), .req_ready(rdy5),
    .req_we(1'b0), .req_size(2'd0), .req_signed(1'b0), .req_addr(12'h000),
    .req_wdata(32'd0), .req_pc(32'd0), .resp_valid(rv5),
    .resp_rdata(rd5), .resp_err(er5), .dbg_state(st5)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: memory as a flat byte array, little-endian.
  task automatic model_apply(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [11:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err);
    int n;
    int a;
    logic [31:0] v;
    rdata = '0;
    err   = 1'b0;
    a     = int'(addr);
    n     = (size == 2'd0) ? 4 : (size == 2'd1) ? 1 : (size == 2'd2) ? 2 : 0;
    if (n == 0 || (a % n) != 0) begin
      err = 1'b1;
      return;
    end
    if ((a / 4) >= DEPTH) return;
    if (we) begin
      for (int i = 0; i < n; i++) mem_b[a + i] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(mem_b[a + i]) << (8 * i));
      if (sgn && n < 4 && v[8*n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      rdata = v;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH * 4; i++) mem_b[i] = 8'h00;
  endtask

  // One full transaction on the main DUT with latency and ready checks.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [11:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err);
    int k;
    bit got;
    rdata = 'x;
    err   = 1'bx;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_pc     = $urandom;
    k = 0;
    while (!req_ready && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(k), 32'(0));
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    got = 1'b0;
    for (k = 1; k <= BUDGET; k++) begin
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      check("resp_timeout", 32'(0), 32'(1));
      return;
    end
    check("latency", 32'(k), 32'(MAIN_LAT));
    check("ready_low_in_resp", 32'(req_ready), 32'(0));
    rdata = resp_rdata;
    err   = resp_err;
    @(negedge clk);
    check("resp_one_cycle", 32'(resp_valid), 32'(0));
    check("ready_after_resp", 32'(req_ready), 32'(1));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] m_rd;
    logic        m_er;
    logic [32:0] e;
    int          nrv;
    int          acc1[$], rsp1[$], acc5[$], rsp5[$];

    tbl.push_back('{"sw_deadbeef",  1'b1, SIZE_WORD, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0,        1'b0});
    tbl.push_back('{"lw_010",       1'b0, SIZE_WORD, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{"sw_11223344",  1'b1, SIZE_WORD, 1'b0, 12'h020, 32'h11223344, 32'h0,        1'b0});
    tbl.push_back('{"sb_021",       1'b1, SIZE_BYTE, 1'b0, 12'h021, 32'h123456AA, 32'h0,        1'b0});
    tbl.push_back('{"sh_022",       1'b1, SIZE_HALF, 1'b0, 12'h022, 32'hFFFF5566, 32'h0,        1'b0});
    tbl.push_back('{"lw_020",       1'b0, SIZE_WORD, 1'b0, 12'h020, 32'h0,        32'h5566AA44, 1'b0});
    tbl.push_back('{"lbu_021",      1'b0, SIZE_BYTE, 1'b0, 12'h021, 32'h0,        32'h000000AA, 1'b0});
    tbl.push_back('{"lb_021",       1'b0, SIZE_BYTE, 1'b1, 12'h021, 32'h0,        32'hFFFFFFAA, 1'b0});
    tbl.push_back('{"lh_022",       1'b0, SIZE_HALF, 1'b1, 12'h022, 32'h0,        32'h00005566, 1'b0});
    tbl.push_back('{"sw_80007fff",  1'b1, SIZE_WORD, 1'b0, 12'h030, 32'h80007FFF, 32'h0,        1'b0});
    tbl.push_back('{"lh_032",       1'b0, SIZE_HALF, 1'b1, 12'h032, 32'h0,        32'hFFFF8000, 1'b0});
    tbl.push_back('{"lhu_032",      1'b0, SIZE_HALF, 1'b0, 12'h032, 32'h0,        32'h00008000, 1'b0});
    tbl.push_back('{"sh_023_err",   1'b1, SIZE_HALF, 1'b0, 12'h023, 32'h00001234, 32'h0,        1'b1});
    tbl.push_back('{"sw_012_err",   1'b1, SIZE_WORD, 1'b0, 12'h012, 32'hCAFEF00D, 32'h0,        1'b1});
    tbl.push_back('{"lw_010_kept",  1'b0, SIZE_WORD, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{"lw_020_kept",  1'b0, SIZE_WORD, 1'b0, 12'h020, 32'h0,        32'h5566AA44, 1'b0});
    tbl.push_back('{"ld_size3",     1'b0, SIZE_BAD,  1'b0, 12'h020, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{"st_size3",     1'b1, SIZE_BAD,  1'b0, 12'h010, 32'h0BADF00D, 32'h0,        1'b1});
    tbl.push_back('{"lh_031_err",   1'b0, SIZE_HALF, 1'b1, 12'h031, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{"lbu_033",      1'b0, SIZE_BYTE, 1'b0, 12'h033, 32'h0,        32'h00000080, 1'b0});
    tbl.push_back('{"lb_030",       1'b0, SIZE_BYTE, 1'b1, 12'h030, 32'h0,        32'hFFFFFFFF, 1'b0});
    tbl.push_back('{"lw_030_sgn",   1'b0, SIZE_WORD, 1'b1, 12'h030, 32'h0,        32'h80007FFF, 1'b0});
    tbl.push_back('{"lw_010_final", 1'b0, SIZE_WORD, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF, 1'b0});

    model_clear();

    // Reset state.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_ready", 32'(req_ready), 32'(1));
    check("rst_resp_valid", 32'(resp_valid), 32'(0));
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", 32'(resp_err), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_state_l1", 32'(st1), 32'(ST_IDLE));
    check("rst_state_l5", 32'(st5), 32'(ST_IDLE));

    // Directed table.
    foreach (tbl[i]) begin
      model_apply(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, m_rd, m_er);
      do_req(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, rd, er);
      check({tbl[i].name, "_rdata"}, rd, tbl[i].exp_rdata);
      check({tbl[i].name, "_err"}, 32'(er), 32'(tbl[i].exp_err));
    end

    // Response data holds while idle.
    repeat (3) @(negedge clk);
    check("hold_rdata", resp_rdata, 32'hDEADBEEF);
    check("hold_valid_low", 32'(resp_valid), 32'(0));

    // Reset during WAIT of a store to 0x040: dropped, memory cleared.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SIZE_WORD; req_signed = 1'b0;
    req_addr = 12'h040; req_wdata = 32'h12345678; req_pc = 32'h0000_0100;
    check("mid_rst_ready", 32'(req_ready), 32'(1));
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_rst_in_wait", 32'(dbg_state), 32'(ST_WAIT));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_ready_after", 32'(req_ready), 32'(1));
    check("mid_rst_rdata_clr", resp_rdata, 32'h0);
    nrv = 0;
    repeat (6) begin
      if (resp_valid) nrv++;
      @(negedge clk);
    end
    check("mid_rst_no_resp", 32'(nrv), 32'(0));
    model_clear();
    do_req(1'b0, SIZE_WORD, 1'b0, 12'h040, 32'h0, rd, er);
    check("mid_rst_lw_040", rd, 32'h0);
    do_req(1'b0, SIZE_WORD, 1'b0, 12'h010, 32'h0, rd, er);
    check("mid_rst_lw_010_cleared", rd, 32'h0);

    // Random traffic against the byte-array model.
    for (int i = 0; i < 150; i++) begin
      logic        r_we;
      logic [1:0]  r_size;
      logic        r_sgn;
      logic [11:0] r_addr;
      logic [31:0] r_wdata;
      r_we    = 1'($urandom_range(0, 1));
      r_size  = 2'($urandom_range(0, 3));
      r_sgn   = 1'($urandom_range(0, 1));
      r_addr  = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 63));
      r_wdata = $urandom;
      model_apply(r_we, r_size, r_sgn, r_addr, r_wdata, m_rd, m_er);
      exp_q.push_back({m_er, m_rd});
      do_req(r_we, r_size, r_sgn, r_addr, r_wdata, rd, er);
      e = exp_q.pop_front();
      check("rand_rdata", rd, e[31:0]);
      check("rand_err", 32'(er), 32'(e[32]));
    end

    // Throughput with req_valid held high at LATENCY 1 and 5.
    @(negedge clk);
    v1 = 1'b1;
    v5 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (v1 && rdy1) acc1.push_back(c);
      if (rv1) begin
        rsp1.push_back(c);
        check("l1_rdata", rd1, 32'h0);
      end
      if (v5 && rdy5) acc5.push_back(c);
      if (rv5) begin
        rsp5.push_back(c);
        check("l5_err", 32'(er5), 32'(0));
      end
      @(negedge clk);
    end
    v1 = 1'b0;
    v5 = 1'b0;
    check("l1_accept_count", 32'(acc1.size()), 32'(20));
    check("l5_accept_count", 32'(acc5.size()), 32'(7));
    for (int i = 1; i < acc1.size(); i++) check("l1_accept_gap", 32'(acc1[i] - acc1[i-1]), 32'(2));
    for (int i = 1; i < acc5.size(); i++) check("l5_accept_gap", 32'(acc5[i] - acc5[i-1]), 32'(6));
    for (int i = 0; i < rsp1.size(); i++) check("l1_resp_time", 32'(rsp1[i]), 32'(acc1[i] + 1));
    for (int i = 0; i < rsp5.size(); i++) check("l5_resp_time", 32'(rsp5[i]), 32'(acc5[i] + 5));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
